// File: rtl/fmap_collector_serializer_pkg.sv
// Shared geometry defaults, output-map size helpers and FSM state encoding
// for the feature-map collector/serializer.
package fmap_collector_serializer_pkg;

    localparam int DEF_IMG_WIDTH   = 28;
    localparam int DEF_IMG_HEIGHT  = 28;
    localparam int DEF_KERNEL_SIZE = 3;

    // Valid-convolution output edge for a given input edge and kernel edge.
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/fmap_collector_serializer_buf.sv
// N x 1 bit storage for one output feature map: async clear, one write
// port and one combinational read port.
module fmap_bit_buffer #(
    parameter int N     = 676,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic             wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic             rdata
);

    logic [N-1:0] r_mem;

    // Storage write; whole array cleared on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/fmap_collector_serializer.sv
// Collects one binarized feature map (raster order), then serializes it
// back out as a 1-bit valid/ready pixel stream.
module fmap_collector_serializer
    import fmap_collector_serializer_pkg::*;
#(
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic bit_in,
    input  logic valid_in,
    output logic in_ready,
    output logic pixel_out,
    output logic valid_out,
    input  logic ready_in,
    output logic frame_done,
    output logic overflow
);

    localparam int OUT_W = out_dim(IMG_WIDTH, KERNEL_SIZE);
    localparam int OUT_H = out_dim(IMG_HEIGHT, KERNEL_SIZE);
    localparam int N     = OUT_W * OUT_H;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic             r_in_ready;
    logic             r_valid_out;
    logic             r_overflow;

    logic w_we;
    logic w_rdata;
    logic w_accept;

    assign w_we     = (r_state == ST_FILL) && valid_in;
    assign w_accept = r_valid_out && ready_in;

    fmap_bit_buffer #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (w_we),
        .waddr   (r_wr_idx),
        .wdata   (bit_in),
        .raddr   (r_rd_idx),
        .rdata   (w_rdata)
    );

    // FSM, index counters and registered handshake flags.
    // in_ready/valid_out are registered copies of the state, so in_ready
    // stays low through the cycle that accepts the final pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_FILL;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_in_ready  <= 1'b1;
            r_valid_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (valid_in && !r_in_ready) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_FILL: begin
                    if (valid_in) begin
                        if (r_wr_idx == LAST) begin
                            r_state     <= ST_DRAIN;
                            r_wr_idx    <= '0;
                            r_rd_idx    <= '0;
                            r_in_ready  <= 1'b0;
                            r_valid_out <= 1'b1;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_accept) begin
                        if (r_rd_idx == LAST) begin
                            r_state     <= ST_FILL;
                            r_rd_idx    <= '0;
                            r_in_ready  <= 1'b1;
                            r_valid_out <= 1'b0;
                        end else begin
                            r_rd_idx <= r_rd_idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign valid_out  = r_valid_out;
    assign pixel_out  = r_valid_out & w_rdata;
    assign frame_done = w_accept && (r_rd_idx == LAST);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_fmap_collector_serializer.sv
// Self-checking bench for fmap_collector_serializer: table-driven frames
// plus hand-written overflow, back-to-back and reset-mid-drain sequences.
module tb_fmap_collector_serializer;

    localparam int W = 26;
    localparam int N = W * W;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic bit_in = 1'b0;
    logic valid_in = 1'b0;
    logic ready_in = 1'b0;
    logic in_ready, pixel_out, valid_out, frame_done, overflow;

    int errors = 0;
    int checks = 0;
    logic sb_q[$];

    typedef struct {
        string name;
        int    pat;      // 0 quadrant, 1 checkerboard, 2 all ones, 3 all zeros
        int    rdy_pct;  // ready_in probability in percent
        int    gaps;     // insert random valid_in gaps while filling
        int    exp_ones;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    fmap_collector_serializer #(
        .IMG_WIDTH   (28),
        .IMG_HEIGHT  (28),
        .KERNEL_SIZE (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_in     (bit_in),
        .valid_in   (valid_in),
        .in_ready   (in_ready),
        .pixel_out  (pixel_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pat_bit(input int pat, input int idx);
        int row = idx / W;
        int col = idx % W;
        case (pat)
            0: return (row < 13) && (col < 13);
            1: return ((row + col) % 2) == 1;
            2: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Enters and leaves at posedge+1.
    task automatic feed_frame(input int pat, input int gaps);
        int wt = 0;
        while (!in_ready && wt < 100) begin
            @(posedge clk); #1;
            wt++;
        end
        check("in_ready_before_fill", in_ready, 1);
        for (int i = 0; i < N; i++) begin
            if (gaps != 0 && $urandom_range(3) == 0) begin
                valid_in = 1'b0;
                @(posedge clk); #1;
            end
            valid_in = 1'b1;
            bit_in   = pat_bit(pat, i);
            sb_q.push_back(bit_in);
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        bit_in   = 1'b0;
        check("latency_valid_out", valid_out, 1);
        check("drain_in_ready", in_ready, 0);
    endtask

    // Enters and leaves at posedge+1; stops after stop_at accepted pixels.
    task automatic drain_frame(input int rdy_pct, input int stop_at,
                               output int n_valid, output int n_done, output int n_ones);
        int   acc = 0;
        int   cyc = 0;
        logic hold = 1'b0;
        logic hold_val = 1'b0;
        logic exp;
        n_valid = 0;
        n_done  = 0;
        n_ones  = 0;
        while (acc < stop_at && cyc < 20 * N) begin
            ready_in = ($urandom_range(99) < rdy_pct);
            #4;
            if (hold) check("hold_stable", pixel_out, hold_val);
            hold = 1'b0;
            if (frame_done) n_done++;
            if (valid_out) begin
                n_valid++;
                if (ready_in) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: got pixel %0d expected none", pixel_out);
                    end else begin
                        exp = sb_q.pop_front();
                        check("pixel", pixel_out, exp);
                    end
                    check("frame_done", frame_done, (acc == N - 1));
                    if (acc == N - 1) check("in_ready_last_accept", in_ready, 0);
                    n_ones += pixel_out;
                    acc++;
                end else begin
                    hold = 1'b1;
                    hold_val = pixel_out;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        ready_in = 1'b0;
        if (acc < stop_at) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d accepts expected %0d", acc, stop_at);
        end
    endtask

    task automatic after_frame_checks();
        check("post_valid_out", valid_out, 0);
        check("post_in_ready", in_ready, 1);
        check("post_frame_done", frame_done, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_valid_out", valid_out, 0);
        check("rst_pixel_out", pixel_out, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        sb_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int nv, nd, no;
        vecs[0] = '{"quadrant",   0, 100, 0, 169};
        vecs[1] = '{"checker_bp", 1, 50,  1, 338};
        vecs[2] = '{"ones_bp",    2, 30,  0, 676};
        vecs[3] = '{"zeros_gaps", 3, 100, 1, 0};

        do_reset();

        foreach (vecs[v]) begin
            feed_frame(vecs[v].pat, vecs[v].gaps);
            drain_frame(vecs[v].rdy_pct, N, nv, nd, no);
            if (vecs[v].rdy_pct == 100) check({vecs[v].name, "_valid_cycles"}, nv, N);
            check({vecs[v].name, "_done_pulses"}, nd, 1);
            check({vecs[v].name, "_ones"}, no, vecs[v].exp_ones);
            after_frame_checks();
        end
        check("no_overflow_yet", overflow, 0);

        // Overflow: stray input during drain of an all-zero frame.
        do_reset();
        feed_frame(3, 0);
        valid_in = 1'b1;
        bit_in   = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        bit_in   = 1'b0;
        check("overflow_set", overflow, 1);
        check("overflow_valid_held", valid_out, 1);
        drain_frame(100, N, nv, nd, no);
        check("overflow_zero_ones", no, 0);
        check("overflow_done", nd, 1);
        feed_frame(1, 0);
        drain_frame(60, N, nv, nd, no);
        check("overflow_sticky", overflow, 1);
        check("overflow_next_ones", no, 338);

        // Back-to-back: all ones then all zeros, input resuming immediately.
        do_reset();
        feed_frame(2, 0);
        drain_frame(100, N, nv, nd, no);
        check("b2b_a_ones", no, N);
        check("b2b_a_done", nd, 1);
        after_frame_checks();
        feed_frame(3, 0);
        drain_frame(100, N, nv, nd, no);
        check("b2b_b_ones", no, 0);
        check("b2b_b_done", nd, 1);
        check("b2b_b_valid_cycles", nv, N);

        // Reset in the middle of a drain, then a clean frame from index 0.
        do_reset();
        feed_frame(0, 0);
        drain_frame(100, 300, nv, nd, no);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_valid_out", valid_out, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_pixel_out", pixel_out, 0);
        sb_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        feed_frame(1, 0);
        drain_frame(100, N, nv, nd, no);
        check("midrst_next_ones", no, 338);
        check("midrst_next_done", nd, 1);
        after_frame_checks();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
